// File: rtl/uart_resp_tx.sv
// ---------------------------------------------------------------------------
// uart_resp_tx
// Response stage of the UART-to-I2C bridge. A completed 16-bit read word is
// framed as HEADER, rd_data[15:8], rd_data[7:0] (plus CHK when the optional
// checksum is built) and shifted out on TXD as 8N1 UART. A one-deep pending
// buffer holds a second completion that arrives while a packet is in flight.
//
// Optional feature macro: RESP_CHECKSUM_EN
//   defined   : 4th byte CHK = HEADER ^ rd_data[15:8] ^ rd_data[7:0]
//   undefined : 3-byte packet, no checksum logic
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   rd_data   in   read word, sampled only when rd_valid = 1
//   rd_valid  in   single-cycle completion strobe
//   TXD       out  UART serial out, idle high
//   busy      out  packet shifting or pending
//   overflow  out  one-cycle pulse when a completion is dropped
// ---------------------------------------------------------------------------
module uart_resp_tx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rd_data,
  input  logic        rd_valid,
  output logic        TXD,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned BIT_DIV = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W   = $clog2(BIT_DIV);
`ifdef RESP_CHECKSUM_EN
  localparam int unsigned NBYTES  = 4;
`else
  localparam int unsigned NBYTES  = 3;
`endif
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_DIV - 1);
  localparam logic [1:0]       BYTE_LAST = 2'(NBYTES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_t;

  // State registers
  state_t           r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [1:0]       r_byte_idx;
  logic [15:0]      r_word;
  logic             r_pend_valid;
  logic [15:0]      r_pend_word;
  logic             r_overflow;

  // Next-state values
  state_t           w_state_next;
  logic [CNT_W-1:0] w_baud_next;
  logic [2:0]       w_bit_next;
  logic [1:0]       w_byte_next;
  logic [15:0]      w_word_next;
  logic             w_pend_valid_next;
  logic [15:0]      w_pend_word_next;
  logic             w_overflow_next;

  // Control strobes
  logic             w_bit_end;
  logic             w_pkt_end;
  logic             w_load;
  logic [15:0]      w_load_word;
  logic             w_direct;
  logic             w_drain;
  logic [7:0]       w_cur_byte;
  logic             w_txd;

`ifdef RESP_CHECKSUM_EN
  logic [7:0]       r_chk;
  logic [7:0]       w_chk_next;
`endif

  assign w_bit_end = (r_baud_cnt == BAUD_LAST);
  // Last stop bit of the last byte finishes on this edge.
  assign w_pkt_end = (r_state == StStop) && w_bit_end && (r_byte_idx == BYTE_LAST);
  assign w_drain   = w_pkt_end && r_pend_valid;
  // A strobe goes straight into the shift word when nothing else is queued
  // and the shifter is (or is about to become) free.
  assign w_direct  = rd_valid && ((r_state == StIdle) || (w_pkt_end && !r_pend_valid));

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next      = r_state;
    w_baud_next       = r_baud_cnt;
    w_bit_next        = r_bit_idx;
    w_byte_next       = r_byte_idx;
    w_word_next       = r_word;
    w_pend_valid_next = r_pend_valid;
    w_pend_word_next  = r_pend_word;
    w_overflow_next   = 1'b0;
    w_load            = 1'b0;
    w_load_word       = rd_data;

    if (r_state != StIdle) begin
      w_baud_next = r_baud_cnt + CNT_W'(1);
    end

    unique case (r_state)
      StIdle: begin
        if (rd_valid) begin
          w_load = 1'b1;
        end
      end
      StStart: begin
        if (w_bit_end) begin
          w_state_next = StData;
          w_baud_next  = '0;
          w_bit_next   = 3'd0;
        end
      end
      StData: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_next = StStop;
          end else begin
            w_bit_next = r_bit_idx + 3'd1;
          end
        end
      end
      StStop: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          if (r_byte_idx == BYTE_LAST) begin
            w_byte_next = 2'd0;
            if (r_pend_valid) begin
              // Back-to-back: pending word starts with zero gap.
              w_load      = 1'b1;
              w_load_word = r_pend_word;
            end else if (rd_valid) begin
              w_load = 1'b1;
            end else begin
              w_state_next = StIdle;
            end
          end else begin
            w_byte_next  = r_byte_idx + 2'd1;
            w_state_next = StStart;
          end
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    if (w_load) begin
      w_state_next = StStart;
      w_baud_next  = '0;
      w_bit_next   = 3'd0;
      w_byte_next  = 2'd0;
      w_word_next  = w_load_word;
    end

    // Pending buffer: a drain frees the slot on the same edge, so a strobe
    // landing there is stored rather than dropped.
    if (w_drain) begin
      w_pend_valid_next = 1'b0;
    end
    if (rd_valid && !w_direct) begin
      if (!r_pend_valid || w_drain) begin
        w_pend_valid_next = 1'b1;
        w_pend_word_next  = rd_data;
      end else begin
        w_overflow_next = 1'b1;
      end
    end
  end

`ifdef RESP_CHECKSUM_EN
  always_comb begin
    w_chk_next = r_chk;
    if (w_load) begin
      w_chk_next = HEADER ^ w_load_word[15:8] ^ w_load_word[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk <= 8'h00;
    end else begin
      r_chk <= w_chk_next;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_baud_cnt   <= '0;
      r_bit_idx    <= 3'd0;
      r_byte_idx   <= 2'd0;
      r_word       <= 16'h0000;
      r_pend_valid <= 1'b0;
      r_pend_word  <= 16'h0000;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_baud_cnt   <= w_baud_next;
      r_bit_idx    <= w_bit_next;
      r_byte_idx   <= w_byte_next;
      r_word       <= w_word_next;
      r_pend_valid <= w_pend_valid_next;
      r_pend_word  <= w_pend_word_next;
      r_overflow   <= w_overflow_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_cur_byte = HEADER;
    case (r_byte_idx)
      2'd0:    w_cur_byte = HEADER;
      2'd1:    w_cur_byte = r_word[15:8];
      2'd2:    w_cur_byte = r_word[7:0];
`ifdef RESP_CHECKSUM_EN
      2'd3:    w_cur_byte = r_chk;
`endif
      default: w_cur_byte = HEADER;
    endcase
  end

  // TXD decodes directly from reset-cleared state so reset forces idle-high
  // without waiting for a clock edge.
  always_comb begin
    w_txd = 1'b1;
    unique case (r_state)
      StStart: w_txd = 1'b0;
      StData:  w_txd = w_cur_byte[r_bit_idx];
      default: w_txd = 1'b1;
    endcase
  end

  assign TXD      = w_txd;
  assign busy     = (r_state != StIdle) || r_pend_valid;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_resp_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_resp_tx
// Self-checking bench for uart_resp_tx at BIT_DIV = 10. The reference model
// keeps a queue of expected TXD levels (one entry per clock) built from the
// packet/framing rules, plus a one-deep pending word.
// ---------------------------------------------------------------------------
module tb_uart_resp_tx;

  localparam int unsigned BD = 10;

  logic        clk;
  logic        rst;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        TXD;
  logic        busy;
  logic        overflow;

  uart_resp_tx #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000),
    .HEADER  (8'hA5)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .TXD     (TXD),
    .busy    (busy),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_mis;
  string       g_scn;

  // Reference model state
  bit          m_q[$];
  bit          m_pend;
  logic [15:0] m_pend_word;
  bit          m_ovf;
  int unsigned ovf_seen;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", g_scn, tag, obs, exp, $time);
    end
  endtask

  function automatic void push_frame(input logic [15:0] w);
    logic [7:0] b[4];
    logic [7:0] hdr;
    int         nb;
    hdr  = 8'hA5;
    b[0] = hdr;
    b[1] = w[15:8];
    b[2] = w[7:0];
    b[3] = hdr ^ w[15:8] ^ w[7:0];
`ifdef RESP_CHECKSUM_EN
    nb = 4;
`else
    nb = 3;
`endif
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < BD; c++) m_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
        for (int c = 0; c < BD; c++) m_q.push_back(b[k][i]);
      end
      for (int c = 0; c < BD; c++) m_q.push_back(1'b1);
    end
  endfunction

  // Advance the model by one clock edge with the strobe seen on that edge.
  function automatic void model_edge(input bit v, input logic [15:0] d);
    if (m_q.size() > 0) void'(m_q.pop_front());
    m_ovf = 1'b0;
    if (m_q.size() == 0 && m_pend) begin
      push_frame(m_pend_word);
      m_pend = 1'b0;
    end
    if (v) begin
      if (m_q.size() == 0) begin
        push_frame(d);
      end else if (!m_pend) begin
        m_pend      = 1'b1;
        m_pend_word = d;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endfunction

  task automatic step(input bit v, input logic [15:0] d);
    logic exp_txd;
    rd_valid = v;
    rd_data  = v ? d : 16'($urandom);
    @(posedge clk);
    #1;
    model_edge(v, d);
    exp_txd = (m_q.size() > 0) ? m_q[0] : 1'b1;
    check_eq("txd", 32'(TXD), 32'(exp_txd));
    check_eq("busy", 32'(busy), 32'((m_q.size() > 0) || m_pend));
    check_eq("ovf", 32'(overflow), 32'(m_ovf));
    if (overflow) ovf_seen++;
    rd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000);
  endtask

  initial begin
    n_cmp    = 0;
    n_mis    = 0;
    m_pend   = 1'b0;
    m_ovf    = 1'b0;
    ovf_seen = 0;
    rst      = 1'b1;
    rd_valid = 1'b0;
    rd_data  = 16'h0000;

    g_scn = "reset";
    repeat (3) @(posedge clk);
    #1;
    check_eq("txd", 32'(TXD), 32'd1);
    check_eq("busy", 32'(busy), 32'd0);
    check_eq("ovf", 32'(overflow), 32'd0);
    rst = 1'b0;

    g_scn = "single_1234";
    step(1'b1, 16'h1234);
    idle(310);

    g_scn = "pending_beef_0001";
    ovf_seen = 0;
    step(1'b1, 16'hBEEF);
    idle(49);
    step(1'b1, 16'h0001);
    idle(620);
    check_eq("ovf_count", ovf_seen, 32'd0);

    g_scn = "overflow_3strobes";
    ovf_seen = 0;
    step(1'b1, 16'h1111);
    idle(19);
    step(1'b1, 16'h2222);
    idle(19);
    step(1'b1, 16'h3333);
    idle(620);
    check_eq("ovf_count", ovf_seen, 32'd1);

    g_scn = "midpacket_reset";
    step(1'b1, 16'h5A5A);
    idle(19);
    step(1'b1, 16'hC3C3);
    idle(130);
    #2;
    rst = 1'b1;
    #1;
    check_eq("txd_async", 32'(TXD), 32'd1);
    check_eq("busy_async", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check_eq("ovf_in_rst", 32'(overflow), 32'd0);
    m_q.delete();
    m_pend = 1'b0;
    m_ovf  = 1'b0;
    rst    = 1'b0;
    check_eq("busy_after_rst", 32'(busy), 32'd0);
    step(1'b1, 16'h00FF);
    idle(310);

    g_scn = "drain_edge";
    ovf_seen = 0;
    step(1'b1, 16'hA001);
    idle(4);
    step(1'b1, 16'hA002);
    idle(294);
    step(1'b1, 16'hA003);   // same edge the pending buffer drains
    idle(950);
    check_eq("ovf_count", ovf_seen, 32'd0);

    g_scn = "chain_on_end";
    step(1'b1, 16'h7E81);
    idle(299);
    step(1'b1, 16'h0F0F);   // same edge the last stop bit ends
    idle(310);

    g_scn = "random";
    for (int chunk = 0; chunk < 4; chunk++) begin
      int unsigned p;
      p = (chunk == 0) ? 1 : (chunk == 1) ? 3 : (chunk == 2) ? 10 : 40;
      for (int i = 0; i < 1000; i++) begin
        step($urandom_range(0, 99) < p, 16'($urandom));
      end
    end
    idle(1300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
